// File: rtl/data_mem_responder.sv
// Data-memory bus responder: DEPTH x DATA_W RAM behind a cyc/stb/we/ack port.
// It returns a single-cycle ack after WAIT_STATES cycles.
module data_mem_responder #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              data_cyc_i,
   input  logic              data_stb_i,
   input  logic              data_we_i,
   input  logic [ADDR_W-1:0] data_adr_i,
   input  logic [DATA_W-1:0] data_dat_i,
   output logic [DATA_W-1:0] data_dat_o,
   output logic              data_ack_o
);

   localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam bit          NoWait  = (WAIT_STATES == 0);
   localparam logic [3:0]  CntLoad = NoWait ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic {StIdle, StWait} state_e;

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              we_q;
   logic [ADDR_W-1:0] adr_q;
   logic [DATA_W-1:0] dat_q;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              req;
   logic              fire;
   logic              acc_we;
   logic              acc_in_range;
   logic [ADDR_W-1:0] acc_adr;
   logic [DATA_W-1:0] acc_dat;
   logic [IdxW-1:0]   acc_idx;

   assign req = data_cyc_i & data_stb_i;

   // Request fields are captured in cycle N, so later bus changes cannot disturb the transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req && !NoWait) begin
                  state_q <= StWait;
                  cnt_q   <= CntLoad;
                  we_q    <= data_we_i;
                  adr_q   <= data_adr_i;
                  dat_q   <= data_dat_i;
               end
            end
            StWait: begin
               if (!req || cnt_q == 4'd0) begin
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Ack is gated by the live request and by rst_n, so it can never outlast either.
   always_comb begin
      if (NoWait) begin
         acc_we  = data_we_i;
         acc_adr = data_adr_i;
         acc_dat = data_dat_i;
         fire    = rst_n & req & (state_q == StIdle);
      end else begin
         acc_we  = we_q;
         acc_adr = adr_q;
         acc_dat = dat_q;
         fire    = rst_n & req & (state_q == StWait) & (cnt_q == 4'd0);
      end
   end

   assign acc_in_range = 32'(acc_adr) < DEPTH;
   assign acc_idx      = acc_adr[IdxW-1:0];

   always_ff @(posedge clk) begin
      if (fire && acc_we && acc_in_range) begin
         mem_q[acc_idx] <= acc_dat;
      end
   end

   assign data_ack_o = fire;
   assign data_dat_o = (fire && acc_in_range) ? mem_q[acc_idx] : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder.
// Five instances cover different wait-state and depth settings; one shared bus is steered by sel.
module tb_data_mem_responder;

   typedef struct {
      int unsigned cyc;
      bit          chk;
      logic [7:0]  dat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cyc, stb, we;
   logic [7:0] adr, dat;
   logic [2:0] sel;
   logic [4:0] stb_v, acks;
   logic [7:0] dats [5];

   int unsigned cyc_cnt = 0;
   int          n_cmp   = 0;
   int          n_bad   = 0;
   exp_t        sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   assign stb_v = stb ? (5'b00001 << sel) : 5'b00000;

   data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst_n(rst_n), .data_cyc_i(cyc), .data_stb_i(stb_v[0]), .data_we_i(we),
      .data_adr_i(adr), .data_dat_i(dat), .data_dat_o(dats[0]), .data_ack_o(acks[0]));
   data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(1)) u_ws1 (
      .clk(clk), .rst_n(rst_n), .data_cyc_i(cyc), .data_stb_i(stb_v[1]), .data_we_i(we),
      .data_adr_i(adr), .data_dat_i(dat), .data_dat_o(dats[1]), .data_ack_o(acks[1]));
   data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(2)) u_ws2 (
      .clk(clk), .rst_n(rst_n), .data_cyc_i(cyc), .data_stb_i(stb_v[2]), .data_we_i(we),
      .data_adr_i(adr), .data_dat_i(dat), .data_dat_o(dats[2]), .data_ack_o(acks[2]));
   data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .rst_n(rst_n), .data_cyc_i(cyc), .data_stb_i(stb_v[3]), .data_we_i(we),
      .data_adr_i(adr), .data_dat_i(dat), .data_dat_o(dats[3]), .data_ack_o(acks[3]));
   data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_STATES(1)) u_d128 (
      .clk(clk), .rst_n(rst_n), .data_cyc_i(cyc), .data_stb_i(stb_v[4]), .data_we_i(we),
      .data_adr_i(adr), .data_dat_i(dat), .data_dat_o(dats[4]), .data_ack_o(acks[4]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d, sel %0d)",
                  name, act, req, cyc_cnt, sel);
      end
   endtask

   // Monitor: pops one expectation per ack seen on the selected instance.
   always @(negedge clk) begin
      exp_t e;
      check("stray_ack", 32'(acks & ~(5'b00001 << sel)), 32'd0);
      if (acks[sel]) begin
         if (sb.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("ack_cycle", cyc_cnt, e.cyc);
            if (e.chk) check("rd_data", 32'(dats[sel]), 32'(e.dat));
         end
      end else begin
         check("dat_zero_no_ack", 32'(dats[sel]), 32'd0);
         if (sb.size() > 0 && cyc_cnt >= sb[0].cyc) begin
            check("ack_missing", 32'd0, 32'd1);
            void'(sb.pop_front());
         end
      end
   end

   // Called just after a rising edge; that cycle is cycle N. Inputs are scrambled after N.
   task automatic xfer(input logic [2:0] s, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] e, input int ws);
      exp_t x;
      sel = s; we = w; adr = a; dat = d; cyc = 1'b1; stb = 1'b1;
      x.cyc = cyc_cnt + 32'(ws);
      x.chk = !w;
      x.dat = e;
      sb.push_back(x);
      @(posedge clk); #1;
      if (ws > 0) begin
         we = ~w; adr = ~a; dat = ~d;
         repeat (ws) begin @(posedge clk); #1; end
      end
   endtask

   task automatic idle(input int n);
      cyc = 1'b0; stb = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      // Reset with a live request on the zero-wait instance: ack must stay low.
      rst_n = 1'b0; sel = 3'd0; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h10; dat = 8'hEE;
      repeat (2) begin
         @(negedge clk);
         check("reset_ack", 32'(acks), 32'd0);
         for (int i = 0; i < 5; i++) check("reset_dat", 32'(dats[i]), 32'd0);
      end
      @(posedge clk); #1;
      stb = 1'b0; cyc = 1'b0; rst_n = 1'b1;
      idle(2);

      // T1: zero wait states, write then read-after-write back-to-back.
      xfer(3'd0, 1'b1, 8'h10, 8'hA5, 8'h00, 0);
      xfer(3'd0, 1'b0, 8'h10, 8'h00, 8'hA5, 0);
      idle(2);

      // T2: two wait states, preload then read.
      xfer(3'd2, 1'b1, 8'h20, 8'h3C, 8'h00, 2);
      idle(1);
      xfer(3'd2, 1'b0, 8'h20, 8'h00, 8'h3C, 2);
      idle(2);

      // T3: three wait states, aborted write leaves old data; next request waits fully.
      xfer(3'd3, 1'b1, 8'h40, 8'h11, 8'h00, 3);
      idle(1);
      sel = 3'd3; we = 1'b1; adr = 8'h40; dat = 8'h77; cyc = 1'b1; stb = 1'b1;
      @(posedge clk); #1;
      idle(1);
      xfer(3'd3, 1'b0, 8'h40, 8'h00, 8'h11, 3);
      idle(2);

      // T4: DEPTH=128, out-of-range write discarded (no alias onto 0x7F), read gives 0.
      xfer(3'd4, 1'b1, 8'h7F, 8'h22, 8'h00, 1);
      xfer(3'd4, 1'b1, 8'hFF, 8'h11, 8'h00, 1);
      xfer(3'd4, 1'b0, 8'hFF, 8'h00, 8'h00, 1);
      xfer(3'd4, 1'b0, 8'h7F, 8'h00, 8'h22, 1);
      idle(2);

      // T5: reset in cycle N+1 of a write drops it; fresh request acks at N'+2.
      xfer(3'd2, 1'b1, 8'h08, 8'h01, 8'h00, 2);
      idle(1);
      sel = 3'd2; we = 1'b1; adr = 8'h08; dat = 8'h5A; cyc = 1'b1; stb = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      xfer(3'd2, 1'b0, 8'h08, 8'h00, 8'h01, 2);
      idle(2);

      // T6: one wait state, stb held across three reads: acks at N+1, N+3, N+5.
      xfer(3'd1, 1'b1, 8'h01, 8'h31, 8'h00, 1);
      xfer(3'd1, 1'b1, 8'h02, 8'h32, 8'h00, 1);
      xfer(3'd1, 1'b1, 8'h03, 8'h33, 8'h00, 1);
      idle(1);
      xfer(3'd1, 1'b0, 8'h01, 8'h00, 8'h31, 1);
      xfer(3'd1, 1'b0, 8'h02, 8'h00, 8'h32, 1);
      xfer(3'd1, 1'b0, 8'h03, 8'h00, 8'h33, 1);
      idle(3);

      @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
